// File: rtl/mips_pkg.sv
// Shared definitions for the 5-stage MIPS pipeline.
//   fwd_sel_e : operand source select driven by the hazard/forwarding unit
//               into the EXE-stage operand muxes.
//   OP_* / FN_* : opcode and funct field values used by the decoder.
package mips_pkg;

  // Operand source for the EXE-stage A/B muxes.
  typedef enum logic [1:0] {
    FWD_RF   = 2'b00,  // register file read value
    FWD_EALU = 2'b01,  // ALU result of the instruction now in EXE
    FWD_MALU = 2'b10,  // ALU result of the instruction now in MEM
    FWD_MMEM = 2'b11   // load data of the instruction now in MEM
  } fwd_sel_e;

  // Opcode field [31:26].
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // Funct field [5:0] for R-type.
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;
  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the ID-stage decoder and the hazard/forwarding controller.
//   master : decoder side; drives the decoded ID control word, receives
//            forward selects, stall/bubble and the stall counter.
//   slave  : controller side.
// Handshake: none. Every signal is a per-cycle level; the ID inputs are
// valid every cycle and the outputs respond combinationally in that cycle.
interface pipe_hazard_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
);
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic             id_wreg;
  logic             id_m2reg;
  logic [REG_W-1:0] id_dest;
  logic [1:0]       fwda;
  logic [1:0]       fwdb;
  logic             stall;
  logic             bubble;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, id_wreg, id_m2reg, id_dest,
    input  fwda, fwdb, stall, bubble, stall_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, id_wreg, id_m2reg, id_dest,
    output fwda, fwdb, stall, bubble, stall_cnt
  );
endinterface

// File: rtl/hazard_fwd_sel.sv
// Forward-select for one EXE operand.
//   src, use_src        : source register of the ID instruction and whether it is read
//   e_wreg/e_m2reg/e_dest : shadow of the instruction in EXE
//   m_wreg/m_m2reg/m_dest : shadow of the instruction in MEM
//   sel                 : fwd_sel_e code
module hazard_fwd_sel
  import mips_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] src,
  input  logic             use_src,
  input  logic             e_wreg,
  input  logic             e_m2reg,
  input  logic [REG_W-1:0] e_dest,
  input  logic             m_wreg,
  input  logic             m_m2reg,
  input  logic [REG_W-1:0] m_dest,
  output logic [1:0]       sel
);

  // EXE is checked first so the youngest producer wins. A load in EXE has no
  // data yet; skipping it lets the select fall through to MEM/regfile while
  // the stall logic holds the instruction.
  always_comb begin
    sel = FWD_RF;
    if (use_src && e_wreg && !e_m2reg && (e_dest == src) && (e_dest != '0)) begin
      sel = FWD_EALU;
    end else if (use_src && m_wreg && (m_dest == src) && (m_dest != '0)) begin
      sel = m_m2reg ? FWD_MMEM : FWD_MALU;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller beside the ID stage.
//   clk, rst : pipeline clock, synchronous active-high reset
//   hz       : ID control word in; fwda/fwdb, stall, bubble, stall_cnt out
// Shadow registers E (ID/EX) and M (EX/MEM) track the destinations of the
// two older instructions so forwarding and load-use detection are local.
module pipe_hazard_ctrl
  import mips_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.slave hz
);

  logic             e_wreg, e_m2reg, m_wreg, m_m2reg;
  logic [REG_W-1:0] e_dest, m_dest;
  logic [CNT_W-1:0] stall_cnt_q;
  logic             hit_rs, hit_rt, load_use;
  logic [1:0]       sel_a, sel_b;

  hazard_fwd_sel #(.REG_W(REG_W)) u_fwd_a (
    .src(hz.id_rs), .use_src(hz.id_use_rs),
    .e_wreg(e_wreg), .e_m2reg(e_m2reg), .e_dest(e_dest),
    .m_wreg(m_wreg), .m_m2reg(m_m2reg), .m_dest(m_dest),
    .sel(sel_a)
  );

  hazard_fwd_sel #(.REG_W(REG_W)) u_fwd_b (
    .src(hz.id_rt), .use_src(hz.id_use_rt),
    .e_wreg(e_wreg), .e_m2reg(e_m2reg), .e_dest(e_dest),
    .m_wreg(m_wreg), .m_m2reg(m_m2reg), .m_dest(m_dest),
    .sel(sel_b)
  );

  // A load in EXE delivers data only at the end of MEM, so a dependent
  // instruction in ID must wait one cycle; after that it forwards from MEM.
  assign hit_rs   = hz.id_use_rs && (e_dest == hz.id_rs);
  assign hit_rt   = hz.id_use_rt && (e_dest == hz.id_rt);
  assign load_use = e_wreg && e_m2reg && (e_dest != '0) && (hit_rs || hit_rt);

  assign hz.fwda      = sel_a;
  assign hz.fwdb      = sel_b;
  assign hz.stall     = load_use;
  assign hz.bubble    = load_use;
  assign hz.stall_cnt = stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      e_wreg      <= 1'b0;
      e_m2reg     <= 1'b0;
      e_dest      <= '0;
      m_wreg      <= 1'b0;
      m_m2reg     <= 1'b0;
      m_dest      <= '0;
      stall_cnt_q <= '0;
    end else begin
      m_wreg  <= e_wreg;
      m_m2reg <= e_m2reg;
      m_dest  <= e_dest;
      // The bubble enters ID/EX as a no-write instruction.
      if (load_use) begin
        e_wreg  <= 1'b0;
        e_m2reg <= 1'b0;
        e_dest  <= '0;
      end else begin
        e_wreg  <= hz.id_wreg;
        e_m2reg <= hz.id_m2reg;
        e_dest  <= hz.id_dest;
      end
      // Free-running; wraps from all-ones to zero.
      if (load_use) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: a default-width instance and a CNT_W=4
// instance share the same ID stimulus; expected selects are queued when a
// step is driven and popped when the outputs are sampled on the falling edge.
module tb_pipe_hazard_ctrl;
  import mips_pkg::*;

  typedef struct packed {
    logic       r;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic       wreg;
    logic       m2reg;
    logic [4:0] dest;
    logic [1:0] efa;
    logic [1:0] efb;
    logic       est;
  } step_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  logic [5:0]  exp_q[$];
  logic [31:0] exp_cnt = '0;
  logic [3:0]  exp_cnt4 = '0;

  // Reference shadows for the random test.
  logic       me_w = 0, me_m = 0, mm_w = 0, mm_m = 0;
  logic [4:0] me_d = '0, mm_d = '0;

  pipe_hazard_ctrl_if #(.REG_W(5), .CNT_W(32)) ifa ();
  pipe_hazard_ctrl_if #(.REG_W(5), .CNT_W(4))  ifb ();

  assign ifb.id_rs     = ifa.id_rs;
  assign ifb.id_rt     = ifa.id_rt;
  assign ifb.id_use_rs = ifa.id_use_rs;
  assign ifb.id_use_rt = ifa.id_use_rt;
  assign ifb.id_wreg   = ifa.id_wreg;
  assign ifb.id_m2reg  = ifa.id_m2reg;
  assign ifb.id_dest   = ifa.id_dest;

  pipe_hazard_ctrl #(.REG_W(5), .CNT_W(32)) dut    (.clk(clk), .rst(rst), .hz(ifa));
  pipe_hazard_ctrl #(.REG_W(5), .CNT_W(4))  dut_w4 (.clk(clk), .rst(rst), .hz(ifb));

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- drivers ----------------
  function automatic step_t st(input logic [4:0] rs, input logic [4:0] rt,
                               input logic urs, input logic urt,
                               input logic wreg, input logic m2reg,
                               input logic [4:0] dest,
                               input logic [1:0] efa, input logic [1:0] efb,
                               input logic est);
    step_t s;
    s.r = 1'b0; s.rs = rs; s.rt = rt; s.urs = urs; s.urt = urt;
    s.wreg = wreg; s.m2reg = m2reg; s.dest = dest;
    s.efa = efa; s.efb = efb; s.est = est;
    return s;
  endfunction

  function automatic step_t nop();
    return st(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, FWD_RF, FWD_RF, 1'b0);
  endfunction

  task automatic drive(input step_t s);
    rst           = s.r;
    ifa.id_rs     = s.rs;
    ifa.id_rt     = s.rt;
    ifa.id_use_rs = s.urs;
    ifa.id_use_rt = s.urt;
    ifa.id_wreg   = s.wreg;
    ifa.id_m2reg  = s.m2reg;
    ifa.id_dest   = s.dest;
    exp_q.push_back({s.efa, s.efb, s.est, s.est});
  endtask

  // Advance one rising edge and move the expected counters with it.
  task automatic tick(input logic est, input logic r);
    @(posedge clk);
    if (r) begin
      exp_cnt  = '0;
      exp_cnt4 = '0;
    end else if (est) begin
      exp_cnt  = exp_cnt + 32'd1;
      exp_cnt4 = exp_cnt4 + 4'd1;
    end
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    step_t s[2];
    logic [5:0] e, g;
    s[0] = st(5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1, 5'd3, FWD_RF, FWD_RF, 1'b0);
    s[0].r = 1'b1;
    s[1] = st(5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 5'd3, FWD_RF, FWD_RF, 1'b0);
    foreach (s[i]) begin
      drive(s[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      g = {ifa.fwda, ifa.fwdb, ifa.stall, ifa.bubble};
      n_chk++; if (g !== e) begin n_fail++; $display("FAIL reset[%0d] fa/fb/st/bu got %b want %b", i, g, e); end
      n_chk++; if (ifa.stall_cnt !== exp_cnt) begin n_fail++; $display("FAIL reset_cnt[%0d] got %0d want %0d", i, ifa.stall_cnt, exp_cnt); end
      n_chk++; if (ifb.stall_cnt !== exp_cnt4) begin n_fail++; $display("FAIL reset_cnt4[%0d] got %0d want %0d", i, ifb.stall_cnt, exp_cnt4); end
      tick(s[i].est, s[i].r);
    end
  endtask

  task automatic test_back_to_back();
    step_t s[5];
    logic [5:0] e, g;
    s[0] = nop();
    s[1] = nop();
    s[2] = st(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd3, FWD_RF,   FWD_RF,   1'b0);  // add r3
    s[3] = st(5'd3, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd6, FWD_EALU, FWD_RF,   1'b0);  // reads r3
    s[4] = st(5'd3, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, FWD_MALU, FWD_EALU, 1'b0);  // r3 in MEM, r6 in EXE
    foreach (s[i]) begin
      drive(s[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      g = {ifa.fwda, ifa.fwdb, ifa.stall, ifa.bubble};
      n_chk++; if (g !== e) begin n_fail++; $display("FAIL back_to_back[%0d] fa/fb/st/bu got %b want %b", i, g, e); end
      n_chk++; if (ifa.stall_cnt !== exp_cnt) begin n_fail++; $display("FAIL b2b_cnt[%0d] got %0d want %0d", i, ifa.stall_cnt, exp_cnt); end
      tick(s[i].est, s[i].r);
    end
  endtask

  task automatic test_distance2();
    step_t s[5];
    logic [5:0] e, g;
    s[0] = nop();
    s[1] = nop();
    s[2] = st(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5, FWD_RF, FWD_RF,   1'b0);
    s[3] = nop();
    s[4] = st(5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, FWD_RF, FWD_MALU, 1'b0);
    foreach (s[i]) begin
      drive(s[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      g = {ifa.fwda, ifa.fwdb, ifa.stall, ifa.bubble};
      n_chk++; if (g !== e) begin n_fail++; $display("FAIL distance2[%0d] fa/fb/st/bu got %b want %b", i, g, e); end
      tick(s[i].est, s[i].r);
    end
  endtask

  task automatic test_load_use();
    step_t s[6];
    logic [5:0] e, g;
    s[0] = nop();
    s[1] = nop();
    s[2] = st(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd7, FWD_RF,   FWD_RF, 1'b0);  // lw r7
    s[3] = st(5'd7, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd8, FWD_RF,   FWD_RF, 1'b1);  // stalls
    s[4] = st(5'd7, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd8, FWD_MMEM, FWD_RF, 1'b0);  // replay
    s[5] = st(5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, FWD_EALU, FWD_RF, 1'b0);
    foreach (s[i]) begin
      drive(s[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      g = {ifa.fwda, ifa.fwdb, ifa.stall, ifa.bubble};
      n_chk++; if (g !== e) begin n_fail++; $display("FAIL load_use[%0d] fa/fb/st/bu got %b want %b", i, g, e); end
      n_chk++; if (ifa.stall_cnt !== exp_cnt) begin n_fail++; $display("FAIL load_use_cnt[%0d] got %0d want %0d", i, ifa.stall_cnt, exp_cnt); end
      tick(s[i].est, s[i].r);
    end
    n_chk++; if (ifa.stall_cnt !== 32'd1) begin n_fail++; $display("FAIL load_use_total got %0d want 1", ifa.stall_cnt); end
  endtask

  task automatic test_both_operands();
    step_t s[5];
    logic [5:0] e, g;
    s[0] = nop();
    s[1] = nop();
    s[2] = st(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd7, FWD_RF,   FWD_RF,   1'b0);
    s[3] = st(5'd7, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 5'd2, FWD_RF,   FWD_RF,   1'b1);
    s[4] = st(5'd7, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 5'd2, FWD_MMEM, FWD_MMEM, 1'b0);
    foreach (s[i]) begin
      drive(s[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      g = {ifa.fwda, ifa.fwdb, ifa.stall, ifa.bubble};
      n_chk++; if (g !== e) begin n_fail++; $display("FAIL both_ops[%0d] fa/fb/st/bu got %b want %b", i, g, e); end
      n_chk++; if (ifa.stall_cnt !== exp_cnt) begin n_fail++; $display("FAIL both_ops_cnt[%0d] got %0d want %0d", i, ifa.stall_cnt, exp_cnt); end
      tick(s[i].est, s[i].r);
    end
  endtask

  task automatic test_reg0_priority();
    step_t s[12];
    logic [5:0] e, g;
    s[0]  = nop();
    s[1]  = nop();
    s[2]  = st(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, FWD_RF,   FWD_RF,   1'b0);  // alu -> r0
    s[3]  = st(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, FWD_RF,   FWD_RF,   1'b0);  // lw  -> r0
    s[4]  = st(5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, FWD_RF,   FWD_RF,   1'b0);
    s[5]  = st(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd4, FWD_RF,   FWD_RF,   1'b0);  // alu -> r4
    s[6]  = st(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd4, FWD_RF,   FWD_RF,   1'b0);  // alu -> r4
    s[7]  = st(5'd4, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, FWD_EALU, FWD_EALU, 1'b0);  // EXE wins
    s[8]  = st(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd4, FWD_RF,   FWD_RF,   1'b0);  // alu -> r4
    s[9]  = st(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd4, FWD_RF,   FWD_RF,   1'b0);  // lw  -> r4
    s[10] = st(5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, FWD_MALU, FWD_RF,   1'b1);  // EXE load skipped
    s[11] = st(5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, FWD_MMEM, FWD_RF,   1'b0);
    foreach (s[i]) begin
      drive(s[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      g = {ifa.fwda, ifa.fwdb, ifa.stall, ifa.bubble};
      n_chk++; if (g !== e) begin n_fail++; $display("FAIL reg0_prio[%0d] fa/fb/st/bu got %b want %b", i, g, e); end
      tick(s[i].est, s[i].r);
    end
  endtask

  task automatic test_itype_no_rt();
    step_t s[4];
    logic [5:0] e, g;
    s[0] = nop();
    s[1] = nop();
    s[2] = st(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd9, FWD_RF, FWD_RF, 1'b0);  // lw r9
    s[3] = st(5'd1, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0, 5'd9, FWD_RF, FWD_RF, 1'b0);  // addi r9,r1
    foreach (s[i]) begin
      drive(s[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      g = {ifa.fwda, ifa.fwdb, ifa.stall, ifa.bubble};
      n_chk++; if (g !== e) begin n_fail++; $display("FAIL itype[%0d] fa/fb/st/bu got %b want %b", i, g, e); end
      tick(s[i].est, s[i].r);
    end
  endtask

  task automatic test_reset_mid_stall();
    step_t s[5];
    logic [5:0] e, g;
    s[0] = nop();
    s[1] = nop();
    s[2] = st(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd7, FWD_RF, FWD_RF, 1'b0);
    s[3] = st(5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd3, FWD_RF, FWD_RF, 1'b1);
    s[3].r = 1'b1;  // reset lands on the stall edge
    s[4] = st(5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd3, FWD_RF, FWD_RF, 1'b0);
    foreach (s[i]) begin
      drive(s[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      g = {ifa.fwda, ifa.fwdb, ifa.stall, ifa.bubble};
      n_chk++; if (g !== e) begin n_fail++; $display("FAIL rst_mid_stall[%0d] fa/fb/st/bu got %b want %b", i, g, e); end
      n_chk++; if (ifa.stall_cnt !== exp_cnt) begin n_fail++; $display("FAIL rst_mid_cnt[%0d] got %0d want %0d", i, ifa.stall_cnt, exp_cnt); end
      n_chk++; if (ifb.stall_cnt !== exp_cnt4) begin n_fail++; $display("FAIL rst_mid_cnt4[%0d] got %0d want %0d", i, ifb.stall_cnt, exp_cnt4); end
      tick(s[i].est, s[i].r);
    end
  endtask

  task automatic test_wrap();
    step_t ld, use_s, s;
    logic [5:0] e, g;
    ld    = st(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd7, FWD_RF, FWD_RF, 1'b0);
    use_s = st(5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, FWD_RF, FWD_RF, 1'b1);
    for (int n = 0; n < 16; n++) begin
      for (int k = 0; k < 2; k++) begin
        s = (k == 0) ? ld : use_s;
        drive(s);
        @(negedge clk);
        e = exp_q.pop_front();
        g = {ifa.fwda, ifa.fwdb, ifa.stall, ifa.bubble};
        n_chk++; if (g !== e) begin n_fail++; $display("FAIL wrap[%0d.%0d] fa/fb/st/bu got %b want %b", n, k, g, e); end
        n_chk++; if (ifb.stall_cnt !== exp_cnt4) begin n_fail++; $display("FAIL wrap_cnt4[%0d.%0d] got %0d want %0d", n, k, ifb.stall_cnt, exp_cnt4); end
        tick(s.est, s.r);
      end
    end
    drive(nop());
    @(negedge clk);
    void'(exp_q.pop_front());
    n_chk++; if (ifb.stall_cnt !== 4'd0) begin n_fail++; $display("FAIL wrap_to_zero got %0d want 0", ifb.stall_cnt); end
    n_chk++; if (ifa.stall_cnt !== 32'd16) begin n_fail++; $display("FAIL wrap_wide_cnt got %0d want 16", ifa.stall_cnt); end
    tick(1'b0, 1'b0);
  endtask

  // Reference select for the random test, written from the forwarding rules.
  function automatic logic [1:0] model_sel(input logic [4:0] src, input logic u);
    if (u && me_w && !me_m && (me_d == src) && (me_d != 5'd0)) return FWD_EALU;
    if (u && mm_w && (mm_d == src) && (mm_d != 5'd0)) return mm_m ? FWD_MMEM : FWD_MALU;
    return FWD_RF;
  endfunction

  task automatic test_random();
    step_t s;
    logic [5:0] e, g;
    me_w = 0; me_m = 0; me_d = '0; mm_w = 0; mm_m = 0; mm_d = '0;
    for (int i = 0; i < 200; i++) begin
      if (i < 2) begin
        s = nop();
      end else begin
        s.r     = 1'b0;
        s.rs    = 5'($urandom_range(0, 7));
        s.rt    = 5'($urandom_range(0, 7));
        s.urs   = 1'($urandom_range(0, 1));
        s.urt   = 1'($urandom_range(0, 1));
        s.wreg  = 1'($urandom_range(0, 1));
        s.m2reg = s.wreg & 1'($urandom_range(0, 1));
        s.dest  = 5'($urandom_range(0, 7));
        s.est   = me_w && me_m && (me_d != 5'd0) &&
                  ((s.urs && (me_d == s.rs)) || (s.urt && (me_d == s.rt)));
        s.efa   = model_sel(s.rs, s.urs);
        s.efb   = model_sel(s.rt, s.urt);
      end
      drive(s);
      @(negedge clk);
      e = exp_q.pop_front();
      g = {ifa.fwda, ifa.fwdb, ifa.stall, ifa.bubble};
      n_chk++; if (g !== e) begin n_fail++; $display("FAIL random[%0d] fa/fb/st/bu got %b want %b", i, g, e); end
      n_chk++; if (ifa.stall_cnt !== exp_cnt) begin n_fail++; $display("FAIL random_cnt[%0d] got %0d want %0d", i, ifa.stall_cnt, exp_cnt); end
      tick(s.est, s.r);
      mm_w = me_w; mm_m = me_m; mm_d = me_d;
      if (s.est) begin
        me_w = 1'b0; me_m = 1'b0; me_d = '0;
      end else begin
        me_w = s.wreg; me_m = s.m2reg; me_d = s.dest;
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst           = 1'b1;
    ifa.id_rs     = '0;
    ifa.id_rt     = '0;
    ifa.id_use_rs = 1'b0;
    ifa.id_use_rt = 1'b0;
    ifa.id_wreg   = 1'b0;
    ifa.id_m2reg  = 1'b0;
    ifa.id_dest   = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_back_to_back();
    test_distance2();
    test_load_use();
    test_both_operands();
    test_reg0_priority();
    test_itype_no_rt();
    test_reset_mid_stall();
    test_wrap();
    test_random();
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got %0d left want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
